// File: rtl/div_const_pkg.sv
// Shared definitions for the constant-divisor pipeline: width helpers and the
// payload carried from stage to stage.
package div_const_pkg;

   localparam int MAX_W = 64;

   typedef struct packed {
      logic             valid;
      logic [MAX_W-1:0] rem;
      logic [MAX_W-1:0] dvd;
      logic [MAX_W-1:0] quo;
   } div_pl_t;

   localparam int PL_W = $bits(div_pl_t);

   function automatic int clog2(input longint unsigned v);
      int              n;
      longint unsigned one;
      n   = 0;
      one = 1;
      for (int i = 0; i < MAX_W; i++)
         if ((one << i) < v) n = i + 1;
      return n;
   endfunction

   function automatic int flog2(input longint unsigned v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_W; i++)
         if ((v >> i) != 0) n = i;
      return n;
   endfunction

   function automatic int qw_of(input int width, input longint unsigned divisor);
      return width - flog2(divisor);
   endfunction

   function automatic int rw_of(input longint unsigned divisor);
      return clog2(divisor);
   endfunction

endpackage

// File: rtl/div_const_stage.sv
// One pipeline slice: C restoring-division steps on the incoming payload,
// captured in a register that advances only on the global enable.
module div_const_stage
   import div_const_pkg::*;
#(
   parameter int              WIDTH   = 32,
   parameter int              C       = 16,
   parameter longint unsigned DIVISOR = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_en,
   input  logic [PL_W-1:0] i_pl,
   output logic [PL_W-1:0] o_pl
);

   localparam logic [MAX_W-1:0] D = MAX_W'(DIVISOR);

   div_pl_t w_in;
   div_pl_t w_nxt;
   div_pl_t r_pl;
   logic    w_bit;

   assign w_in = div_pl_t'(i_pl);

   // Remainder stays below DIVISOR, so 2r+1 never overflows MAX_W bits.
   always_comb begin
      w_nxt = w_in;
      w_bit = 1'b0;
      for (int k = 0; k < C; k++) begin
         w_nxt.rem = {w_nxt.rem[MAX_W-2:0], w_nxt.dvd[WIDTH-1]};
         w_nxt.dvd = w_nxt.dvd << 1;
         w_bit     = (w_nxt.rem >= D);
         if (w_bit) w_nxt.rem = w_nxt.rem - D;
         w_nxt.quo = {w_nxt.quo[MAX_W-2:0], w_bit};
      end
   end

   // Stage register boundary
   always_ff @(posedge clk) begin
      if (!rst_n)    r_pl <= '0;
      else if (i_en) r_pl <= w_nxt;
   end

   assign o_pl = r_pl;

endmodule

// File: rtl/div_const_pipe.sv
// Pipelined unsigned divide by a constant, STAGES slices of WIDTH/STAGES bits.
// Define DIV_CONST_REM_EN to expose the final remainder on out_r.
module div_const_pipe
   import div_const_pkg::*;
#(
   parameter int              WIDTH   = 32,
   parameter longint unsigned DIVISOR = 5,
   parameter int              STAGES  = 2,
   localparam int             QW      = qw_of(WIDTH, DIVISOR),
   localparam int             RW      = rw_of(DIVISOR)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW-1:0]    out_q
`ifdef DIV_CONST_REM_EN
   ,
   output logic [RW-1:0]    out_r
`endif
);

   localparam longint unsigned MAX_DIV = (64'd1 << WIDTH) - 64'd1;
   localparam bit ILLEGAL = (WIDTH < 2) || (WIDTH > MAX_W - 1) ||
                            (STAGES < 1) || (STAGES > WIDTH) ||
                            ((STAGES >= 1) ? ((WIDTH % STAGES) != 0) : 1'b1) ||
                            (DIVISOR < 2) || (DIVISOR > MAX_DIV);

   logic [PL_W-1:0] w_pl [0:STAGES];
   div_pl_t         w_head;
   div_pl_t         w_tail;
   logic            w_en;

   // A stalled result freezes every slice, so bubbles are never squeezed out.
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   always_comb begin
      w_head       = '0;
      w_head.valid = in_valid;
      w_head.dvd   = MAX_W'(in_x);
   end

   assign w_pl[0] = w_head;

   if (ILLEGAL) begin : g_bad
      $error("div_const_pipe: illegal WIDTH/DIVISOR/STAGES combination");
   end else begin : g_pipe
      for (genvar s = 0; s < STAGES; s++) begin : g_stage
         div_const_stage #(
            .WIDTH   (WIDTH),
            .C       (WIDTH / STAGES),
            .DIVISOR (DIVISOR)
         ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_en),
            .i_pl  (w_pl[s]),
            .o_pl  (w_pl[s+1])
         );
      end
   end

   // Last slice register doubles as the output register
   assign w_tail    = div_pl_t'(w_pl[STAGES]);
   assign out_valid = w_tail.valid;
   assign out_q     = w_tail.quo[QW-1:0];
`ifdef DIV_CONST_REM_EN
   assign out_r     = w_tail.rem[RW-1:0];
`endif

endmodule

// File: tb/tb_div_const_pipe.sv
// Scoreboard bench for div_const_pipe (32/5/2); checks out_r when DIV_CONST_REM_EN is defined.
module tb_div_const_pipe;

   localparam int              WIDTH   = 32;
   localparam longint unsigned DIVISOR = 5;
   localparam int              STAGES  = 2;
   localparam int              QW      = 30;
   localparam int              RW      = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic             out_valid;
   logic             out_ready;
   logic [QW-1:0]    out_q;
`ifdef DIV_CONST_REM_EN
   logic [RW-1:0]    out_r;
`endif

   typedef struct {
      logic [63:0] x;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   acc_cnt = 0;
   bit   lat_en  = 1'b1;

   div_const_pipe #(
      .WIDTH   (WIDTH),
      .DIVISOR (DIVISOR),
      .STAGES  (STAGES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q)
`ifdef DIV_CONST_REM_EN
      ,
      .out_r     (out_r)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Expected results are queued at acceptance and retired in order on each output transfer.
   initial begin
      exp_t        e;
      bit          stall_prev;
      logic [63:0] q_prev;
      stall_prev = 1'b0;
      q_prev     = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_q", 64'(out_q), q_prev);
            end
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: out_q=%0d, no operand outstanding", out_q);
               end else begin
                  e = sb.pop_front();
                  chk("quotient", 64'(out_q), e.x / DIVISOR);
`ifdef DIV_CONST_REM_EN
                  chk("remainder", 64'(out_r), e.x % DIVISOR);
`endif
                  if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
               end
            end
            if (in_valid && in_ready) begin
               e.x   = 64'(in_x);
               e.cyc = cyc;
               e.lat = lat_en;
               sb.push_back(e);
               acc_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            q_prev     = 64'(out_q);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] x);
      int n;
      n        = 0;
      in_x     = x;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      chk("send_accept", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_outstanding", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rand_x();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return WIDTH'($urandom_range(0, 20));
         default: return WIDTH'($urandom());
      endcase
   endfunction

   initial begin
      int target;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_q", 64'(out_q), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All-ones dividend, exact latency
      send(32'hFFFF_FFFF);
      @(negedge clk);
      chk("lat_not_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("max_valid", 64'(out_valid), 64'd1);
      chk("max_q", 64'(out_q), 64'd858993459);
`ifdef DIV_CONST_REM_EN
      chk("max_r", 64'(out_r), 64'd0);
`endif
      @(posedge clk);
      #1;

      // Back-to-back 7, 4, 0
      send(32'd7);
      send(32'd4);
      send(32'd0);
      @(negedge clk);
      chk("b2b_4_valid", 64'(out_valid), 64'd1);
      chk("b2b_4_q", 64'(out_q), 64'd0);
`ifdef DIV_CONST_REM_EN
      chk("b2b_4_r", 64'(out_r), 64'd4);
`endif
      @(negedge clk);
      chk("b2b_0_valid", 64'(out_valid), 64'd1);
      chk("b2b_0_q", 64'(out_q), 64'd0);
`ifdef DIV_CONST_REM_EN
      chk("b2b_0_r", 64'(out_r), 64'd0);
`endif
      @(negedge clk);
      chk("b2b_idle", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // Back-pressure with first result held
      lat_en    = 1'b0;
      out_ready = 1'b0;
      send(32'd100);
      send(32'd107);
      in_x     = 32'd114;
      in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_q", 64'(out_q), 64'd20);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'd114);
      drain();

      // Reset with two operands in flight
      lat_en = 1'b1;
      send(32'd12345);
      send(32'd67890);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_q", 64'(out_q), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // Random traffic with random back-pressure
      lat_en = 1'b0;
      target = acc_cnt + 3000;
      for (int c = 0; c < 40000 && acc_cnt < target; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_x      = rand_x();
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      chk("random_accepted", 64'(acc_cnt >= target), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_const_pipe.md
DIV_CONST_PIPE -- requirements
Module: div_const_pipe

Interface
REQ-001 Parameter WIDTH, default 32, dividend width in bits.
REQ-002 Parameter DIVISOR, default 5, constant unsigned divisor; legal range 2 .. 2^WIDTH-1.
REQ-003 Parameter STAGES, default 2, pipeline depth; legal range 1 .. WIDTH, and WIDTH mod STAGES = 0.
REQ-004 Derived widths: QW = WIDTH - floor(log2(DIVISOR)) is the quotient width; RW = clog2(DIVISOR) is the remainder width (32/5 gives QW=30, RW=3).
REQ-005 clk  input  1  the single clock; every register updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1  in_x is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_x this cycle.
REQ-009 in_x  input  WIDTH  unsigned dividend.
REQ-010 out_valid  output  1  out_q (and out_r when present) are valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_q  output  QW  quotient floor(in_x / DIVISOR).
REQ-013 out_r  output  RW  remainder in_x mod DIVISOR; present only under DIV_CONST_REM_EN.

Function
REQ-014 Digit-serial restoring division: stage s (0..STAGES-1) consumes C = WIDTH/STAGES dividend bits, MSB first, as C steps of r = 2r + bit, then qbit = (r >= DIVISOR), and r = r - DIVISOR when qbit = 1.
REQ-015 Partial remainder is carried between stages in RW bits and is always < DIVISOR; the remaining dividend bits and the partial quotient travel with it.
REQ-016 Each stage output is registered; latency from acceptance to out_valid is exactly STAGES cycles when out_ready is held high.
REQ-017 Global advance enable en = !out_valid || out_ready; in_ready = en; all stages shift only when en = 1.
REQ-018 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-019 While out_valid = 1 and out_ready = 0, out_q, out_r, out_valid and all stage contents hold unchanged.
REQ-020 Bubbles (invalid stage slots) advance with the pipeline and are not squeezed out; the stage valid bit travels with its data.
REQ-021 Throughput is one result per cycle under continuous in_valid = 1 and out_ready = 1.
REQ-022 out_q is the low QW bits of the full WIDTH-bit quotient; the discarded upper bits are zero by construction.
REQ-023 in_x = 0 gives q = 0, r = 0; in_x = 2^WIDTH-1 gives the exact result, with no overflow or saturation.
REQ-024 Illegal parameter combinations trigger an elaboration-time error.

Reset
REQ-025 When rst_n = 0 at a clock edge, every stage valid bit, out_valid, out_q and out_r clear to 0, and all stage data registers clear to 0.
REQ-026 in_ready is 1 during and immediately after reset, since it is derived from out_valid = 0.
REQ-027 Reset asserted mid-operation discards all in-flight operands; no result from before the reset is ever presented.

Configuration
REQ-028 Macro DIV_CONST_REM_EN: when defined, port out_r exists and carries the final remainder, registered alongside out_q.
REQ-029 When DIV_CONST_REM_EN is undefined, port out_r and its output register are absent; the remainder still flows between stages internally, and quotient behaviour and latency are unchanged.

Structure
REQ-030 Shared package div_const_pkg holds the clog2 function, the QW/RW derivation functions, and a stage-payload struct typedef {valid, rem, dividend bits, partial quotient}.
REQ-031 One sub-module div_const_stage implements a combinational C-bit step plus the payload register with enable and synchronous reset; div_const_pipe instantiates it STAGES times via generate.

Verification
REQ-032 WIDTH=32, DIVISOR=5, STAGES=2, out_ready=1; in_x=0xFFFFFFFF -> out_q=858993459 (0x33333333), out_r=0 exactly 2 cycles after acceptance.
REQ-033 in_x=7 -> q=1, r=2; in_x=4 -> q=0, r=4; in_x=0 -> q=0, r=0; issued back-to-back -> three consecutive out_valid cycles in order.
REQ-034 Back-pressure: hold out_ready=0 after the first result -> in_ready=0, outputs hold stable; release -> the remaining results emerge in order with no loss or duplication.
REQ-035 Reset mid-stream: assert rst_n=0 with 2 operands in flight -> next cycle out_valid=0, out_q=0; no stale result afterwards.
REQ-036 Random regression: 10^5 random in_x with random in_valid/out_ready, for configurations (32,5,2), (32,3,4), (16,10,1), (8,255,8), each with and without DIV_CONST_REM_EN -> every out_q/out_r matches the reference model, order preserved.
